ntt_coef_loader: RTL and testbench

//  Input stage directly upstream of the NTT core. Accepts one polynomial of N coefficients over a

---
 rtl/ntt_coef_loader.sv | 75 +++++++
 tb/tb_ntt_coef_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coef_loader.sv
// ntt_coef_loader: streams one polynomial into four coefficient RAM banks, then starts the NTT (bit-reversed placement under LOADER_BITREV_EN)
module ntt_coef_loader #(
  parameter int DATA_W = 32,
  parameter int LOG_N  = 8,
  parameter int Q      = 3329
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [3:0]        ram_we,
  output logic [LOG_N-3:0]  ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ntt_start,
  input  logic              ntt_done,
  output logic              busy,
  output logic              range_err
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, FLUSH = 3'd2, START = 3'd3, WAIT = 3'd4;
  localparam logic [DATA_W-1:0] Q_W = DATA_W'(Q);
  logic [2:0]        state_q, state_d;
  logic [LOG_N-1:0]  k_q, k_d, t;
  logic [3:0]        we_q, we_d;
  logic [LOG_N-3:0]  addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              err_q, err_d;
  logic              xfer, start_load;
`ifdef LOADER_BITREV_EN
  for (genvar i = 0; i < LOG_N; i++) begin : g_rev
    assign t[i] = k_q[LOG_N-1-i];
  end
`else
  assign t = k_q;
`endif
  assign s_ready    = state_q == LOAD;
  assign ntt_start  = state_q == START;
  assign busy       = state_q != IDLE;
  assign xfer       = s_valid && s_ready;
  assign start_load = state_q == IDLE && load_req;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_din    = din_q;
  assign range_err  = err_q;
  always_comb begin
    state_d = start_load                    ? LOAD  :
              (xfer && &k_q)                ? FLUSH :
              state_q == FLUSH              ? START :
              state_q == START              ? WAIT  :
              (state_q == WAIT && ntt_done) ? IDLE  : state_q;
    k_d     = start_load ? '0 : xfer ? k_q + LOG_N'(1) : k_q;
    we_d    = xfer ? 4'b0001 << t[LOG_N-1 -: 2] : 4'b0000;
    addr_d  = xfer ? t[LOG_N-3:0] : addr_q;
    din_d   = xfer ? s_data : din_q;
    err_d   = start_load ? 1'b0 : (xfer && s_data >= Q_W) ? 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_ntt_coef_loader.sv
// tb_ntt_coef_loader: scoreboard and table-driven checks of ntt_coef_loader
module tb_ntt_coef_loader;
  localparam int N = 256;
  logic        clk = 0, rst = 1, load_req = 1, s_valid = 1, ntt_done = 0;
  logic [31:0] s_data = 0;
  logic        s_ready, ntt_start, busy, range_err;
  logic [3:0]  ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_din;
  typedef struct {logic [1:0] bank; logic [5:0] addr; logic [31:0] data;} wr_t;
  typedef struct {int k; int bank; int addr;} vec_t;
  wr_t  exp_q[$];
  vec_t tbl[6];
  int   n_cmp = 0, n_err = 0, cyc = 0, wr_cnt = 0, start_cnt = 0, last_cyc = 0;
  int   log_bank[N], log_addr[N];
  bit   first_pend = 0;
  int   first_bank = -1, first_addr = -1;
  ntt_coef_loader dut (
    .clk(clk), .rst(rst), .load_req(load_req), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ntt_start(ntt_start), .ntt_done(ntt_done), .busy(busy), .range_err(range_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] tmap(input int k);
    logic [7:0] kk, r;
    kk = k[7:0];
    r  = kk;
`ifdef LOADER_BITREV_EN
    for (int i = 0; i < 8; i++) r[i] = kk[7-i];
`endif
    return r;
  endfunction
  always @(negedge clk) begin
    wr_t e;
    int  b;
    if (ram_we != 4'b0000) begin
      wr_cnt++;
      b = ram_we[1] ? 1 : ram_we[2] ? 2 : ram_we[3] ? 3 : 0;
      if (ram_din < N) begin
        log_bank[int'(ram_din)] = b;
        log_addr[int'(ram_din)] = int'(ram_addr);
      end
      if (first_pend) begin
        first_pend = 0;
        first_bank = b;
        first_addr = int'(ram_addr);
      end
      if (exp_q.size() == 0) chk("unexpected_write", {28'd0, ram_we}, 0);
      else begin
        e = exp_q.pop_front();
        chk("ram_we", {28'd0, ram_we}, {28'd0, 4'b0001 << e.bank});
        chk("ram_addr", {26'd0, ram_addr}, {26'd0, e.addr});
        chk("ram_din", ram_din, e.data);
      end
      if (ram_din == 32'd3329) chk("range_err_on_write", {31'd0, range_err}, 1);
    end
    if (ntt_start) start_cnt++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic new_poly();
    for (int i = 0; i < N; i++) begin
      log_bank[i] = -1;
      log_addr[i] = -1;
    end
    wr_cnt = 0;
  endtask
  task automatic do_load();
    load_req = 1;
    step();
    load_req = 0;
    @(negedge clk);
    chk("busy_after_load", {31'd0, busy}, 1);
    chk("range_err_cleared", {31'd0, range_err}, 0);
    chk("s_ready_in_load", {31'd0, s_ready}, 1);
    step();
  endtask
  task automatic stream(input int n, input int gmax, input int bad_k);
    for (int k = 0; k < n; k++) begin
      int         b;
      wr_t        e;
      logic [7:0] t;
      repeat ($urandom_range(gmax, 0)) begin
        s_valid = 0;
        step();
      end
      s_valid = 1;
      s_data  = (k == bad_k) ? 32'd3329 : 32'(k);
      b = 0;
      @(negedge clk);
      while (!s_ready && b < 20) begin
        step();
        @(negedge clk);
        b++;
      end
      if (!s_ready) begin
        chk("handshake_timeout", 0, 1);
        s_valid = 0;
        return;
      end
      t = tmap(k);
      e.bank = t[7:6];
      e.addr = t[5:0];
      e.data = s_data;
      exp_q.push_back(e);
      last_cyc = cyc;
      step();
    end
    s_valid = 0;
  endtask
  task automatic wait_start();
    int b = 0;
    @(negedge clk);
    while (!ntt_start && b < 10) begin
      @(negedge clk);
      b++;
    end
    chk("ntt_start_seen", {31'd0, ntt_start}, 1);
    chk("start_latency", cyc - last_cyc, 2);
    chk("write_count", wr_cnt, N);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  task automatic wait_done(input bit held);
    step();
    @(negedge clk);
    chk("busy_in_wait", {31'd0, busy}, 1);
    if (!held) begin
      load_req = 1;
      repeat (3) begin
        @(negedge clk);
        chk("wait_ignores_load_req", {30'd0, busy, s_ready}, 2);
        step();
      end
      load_req = 0;
      ntt_done = 1;
    end
    step();
    ntt_done = 0;
    @(negedge clk);
    chk("idle_after_done", {31'd0, busy}, 0);
    step();
    @(negedge clk);
    chk("load_req_not_queued", {31'd0, busy}, 0);
  endtask
  task automatic check_table();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl_bank_k%0d", tbl[i].k), log_bank[tbl[i].k], tbl[i].bank);
      chk($sformatf("tbl_addr_k%0d", tbl[i].k), log_addr[tbl[i].k], tbl[i].addr);
    end
  endtask
  initial begin
    int s0;
`ifdef LOADER_BITREV_EN
    tbl = '{'{1, 2, 0}, '{3, 3, 0}, '{254, 1, 63}, '{0, 0, 0}, '{128, 0, 1}, '{255, 3, 63}};
`else
    tbl = '{'{5, 0, 5}, '{64, 1, 0}, '{255, 3, 63}, '{0, 0, 0}, '{128, 2, 0}, '{1, 0, 1}};
`endif
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", {s_ready, ntt_start, busy, range_err, ram_we}, 0);
      chk("rst_addr", {26'd0, ram_addr}, 0);
      chk("rst_din", ram_din, 0);
    end
    step();
    rst = 0;
    s_valid = 0;
    load_req = 0;
    new_poly();
    do_load();
    stream(N, 0, -1);
    wait_start();
    check_table();
    wait_done(0);
    s_valid = 1;
    s_data = 32'd77;
    repeat (3) begin
      @(negedge clk);
      chk("no_ready_before_load", {31'd0, s_ready}, 0);
      step();
    end
    s_valid = 0;
    new_poly();
    do_load();
    stream(N, 3, -1);
    wait_start();
    check_table();
    wait_done(0);
    new_poly();
    do_load();
    stream(N, 1, 10);
    wait_start();
    chk("range_err_at_start", {31'd0, range_err}, 1);
    step();
    @(negedge clk);
    chk("range_err_in_wait", {31'd0, range_err}, 1);
    ntt_done = 1;
    step();
    ntt_done = 0;
    step();
    new_poly();
    do_load();
    ntt_done = 1;
    stream(N, 0, -1);
    wait_start();
    chk("range_err_clean_poly", {31'd0, range_err}, 0);
    wait_done(1);
    new_poly();
    do_load();
    stream(100, 0, -1);
    s0 = start_cnt;
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("midload_rst_idle", {30'd0, busy, s_ready}, 0);
    repeat (5) step();
    chk("midload_no_start", start_cnt, s0);
    chk("midload_queue_empty", exp_q.size(), 0);
    new_poly();
    first_pend = 1;
    do_load();
    stream(N, 1, -1);
    chk("restart_first_bank", first_bank, 0);
    chk("restart_first_addr", first_addr, 0);
    wait_start();
    check_table();
    wait_done(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
